// File: rtl/inferno_input_ctrl_pkg.sv
// inferno_input_ctrl_pkg: joystick bit map, control layouts and default timing for the Inferno input stage.
package inferno_input_ctrl_pkg;

    localparam int JOY_R     = 0;
    localparam int JOY_L     = 1;
    localparam int JOY_D     = 2;
    localparam int JOY_U     = 3;
    localparam int JOY_FA    = 4;
    localparam int JOY_FB    = 5;
    localparam int JOY_FC    = 6;
    localparam int JOY_FD    = 7;
    localparam int JOY_ST1   = 10;
    localparam int JOY_ST2   = 11;
    localparam int JOY_COIN  = 12;
    localparam int JOY_PAUSE = 15;

    localparam int DEF_DEBOUNCE_CYC = 120000;
    localparam int DEF_COIN_CYC     = 600000;
    localparam int DEF_ANA_THRESH   = 48;
    localparam int DEF_ANA_HYST     = 16;

    // any layout code with bit 1 set selects the split layout
    typedef enum logic [1:0] {
        MODE_FIRE  = 2'd0,
        MODE_DUAL  = 2'd1,
        MODE_SPLIT = 2'd2
    } mode_t;

    // MiSTer order {U,D,L,R} to the williams2 nibble order {R,L,D,U}
    function automatic logic [3:0] to_rldu(input logic [3:0] udlr);
        return {udlr[JOY_R], udlr[JOY_L], udlr[JOY_D], udlr[JOY_U]};
    endfunction

endpackage

// File: rtl/inferno_input_ctrl_if.sv
// inferno_input_ctrl_if: raw MiSTer joystick words in, williams2 button/joystick buses out.
interface inferno_input_ctrl_if;

    logic [31:0] joy1;
    logic [31:0] joy2;
    logic [15:0] joy1a;
    logic [15:0] joy2a;
    logic [1:0]  mode;
    logic        pause_en;
    logic [7:0]  BTN;
    logic [7:0]  JA;
    logic        pause_out;
    logic        j2_active;

    modport master (
        output joy1, joy2, joy1a, joy2a, mode, pause_en,
        input  BTN, JA, pause_out, j2_active
    );

    modport slave (
        input  joy1, joy2, joy1a, joy2a, mode, pause_en,
        output BTN, JA, pause_out, j2_active
    );

endinterface

// File: rtl/inferno_input_ctrl_debounce.sv
// input_debounce: accepts a new level only after it has held stable for CYC consecutive cycles.
module input_debounce #(
    parameter int CYC = 120000
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    localparam int W = $clog2(CYC + 1);

    logic [W-1:0] cnt;
    logic         raw_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            raw_q <= 1'b0;
            dout  <= 1'b0;
        end else if (din != raw_q) begin
            raw_q <= din;
            cnt   <= '0;
        end else if (cnt == W'(CYC - 1)) begin
            dout  <= raw_q;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/inferno_input_ctrl.sv
// inferno_input_ctrl: debounces buttons, shapes coin, toggles pause, picks the analog stick
// and encodes the JA/BTN buses sampled by williams2.
module inferno_input_ctrl
    import inferno_input_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int COIN_CYC     = DEF_COIN_CYC,
    parameter int ANA_THRESH   = DEF_ANA_THRESH,
    parameter int ANA_HYST     = DEF_ANA_HYST
) (
    input  logic clk_sys,
    input  logic reset_n,
    inferno_input_ctrl_if.slave io
);

    localparam int CW = $clog2(COIN_CYC + 1);
    localparam logic signed [8:0] ON_LVL  = 9'(ANA_THRESH);
    localparam logic signed [8:0] OFF_LVL = 9'(ANA_THRESH - ANA_HYST);

    logic [31:0]       joy_or;
    logic              st1_deb, st2_deb, coin_deb, pause_deb;
    logic              st1_q, st2_q, coin_deb_q, pause_deb_q, pause_q, j2_q;
    logic [CW-1:0]     coin_cnt;
    logic              ana_r, ana_l, ana_d, ana_u;
    logic [15:0]       stick;
    logic signed [8:0] ax, ay;
    logic [3:0]        dir1, dir2, dir, fire;
    logic [7:0]        ja_d, ja_q;
    logic              unused_joy;

    assign joy_or     = io.joy1 | io.joy2;
    assign unused_joy = ^{joy_or[31:16], joy_or[14:13], joy_or[9:8]};

    input_debounce #(.CYC(DEBOUNCE_CYC)) u_deb_st1 (
        .clk_sys(clk_sys), .reset_n(reset_n), .din(joy_or[JOY_ST1]), .dout(st1_deb)
    );
    input_debounce #(.CYC(DEBOUNCE_CYC)) u_deb_st2 (
        .clk_sys(clk_sys), .reset_n(reset_n), .din(joy_or[JOY_ST2]), .dout(st2_deb)
    );
    input_debounce #(.CYC(DEBOUNCE_CYC)) u_deb_coin (
        .clk_sys(clk_sys), .reset_n(reset_n), .din(joy_or[JOY_COIN]), .dout(coin_deb)
    );
    input_debounce #(.CYC(DEBOUNCE_CYC)) u_deb_pause (
        .clk_sys(clk_sys), .reset_n(reset_n), .din(joy_or[JOY_PAUSE]), .dout(pause_deb)
    );

    // coin edges are only armed once the previous pulse has fully drained
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            st1_q       <= 1'b0;
            st2_q       <= 1'b0;
            coin_deb_q  <= 1'b0;
            pause_deb_q <= 1'b0;
            coin_cnt    <= '0;
            pause_q     <= 1'b0;
            j2_q        <= 1'b0;
        end else begin
            st1_q       <= st1_deb;
            st2_q       <= st2_deb;
            coin_deb_q  <= coin_deb;
            pause_deb_q <= pause_deb;
            coin_cnt    <= (coin_cnt != '0) ? coin_cnt - 1'b1 :
                           (coin_deb && !coin_deb_q) ? CW'(COIN_CYC) : '0;
            pause_q     <= !io.pause_en ? 1'b0 :
                           (pause_deb && !pause_deb_q) ? !pause_q : pause_q;
            j2_q        <= (io.joy1 != '0) ? 1'b0 : (io.joy2 != '0) ? 1'b1 : j2_q;
        end
    end

    assign stick = j2_q ? io.joy2a : io.joy1a;
    assign ax    = {stick[7], stick[7:0]};
    assign ay    = {stick[15], stick[15:8]};

    // 9-bit signed compares keep -128 as a full-scale deflection
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ana_r <= 1'b0;
            ana_l <= 1'b0;
            ana_d <= 1'b0;
            ana_u <= 1'b0;
            ja_q  <= 8'hFF;
        end else begin
            ana_r <= (ax >= ON_LVL)  ? 1'b1 : (ax < OFF_LVL)  ? 1'b0 : ana_r;
            ana_l <= (ax <= -ON_LVL) ? 1'b1 : (ax > -OFF_LVL) ? 1'b0 : ana_l;
            ana_d <= (ay >= ON_LVL)  ? 1'b1 : (ay < OFF_LVL)  ? 1'b0 : ana_d;
            ana_u <= (ay <= -ON_LVL) ? 1'b1 : (ay > -OFF_LVL) ? 1'b0 : ana_u;
            ja_q  <= ~ja_d;
        end
    end

    always_comb begin
        dir1 = to_rldu(io.joy1[3:0]) | {ana_r, ana_l, ana_d, ana_u};
        dir2 = to_rldu(io.joy2[3:0]);
        dir  = dir1 | dir2;
        fire = {joy_or[JOY_FA], joy_or[JOY_FD], joy_or[JOY_FB], joy_or[JOY_FC]};
        ja_d = (io.mode == MODE_FIRE) ? {fire, dir} :
               (io.mode == MODE_DUAL) ? {dir, dir} : {dir2, dir1};
    end

    assign io.BTN       = {5'b0, st1_q, st2_q, coin_cnt != '0};
    assign io.JA        = ja_q;
    assign io.pause_out = pause_q;
    assign io.j2_active = j2_q;

endmodule

// File: tb/tb_inferno_input_ctrl.sv
// tb_inferno_input_ctrl: directed scenarios plus random traffic against a time/arithmetic model
// of the input stage, run with shortened debounce and coin timings.
module tb_inferno_input_ctrl;
    import inferno_input_ctrl_pkg::*;

    localparam int DEB = 8;
    localparam int COIN = 40;
    localparam int THR = 48;
    localparam int REL = 32;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0;
    int errors = 0;
    int coin_hi = 0;

    inferno_input_ctrl_if io();

    inferno_input_ctrl #(.DEBOUNCE_CYC(DEB), .COIN_CYC(COIN)) dut (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .io(io)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // model: buttons as run lengths, coin as an end time, everything else as plain arithmetic
    int k;
    int run[4];
    bit [3:0] raw_prev, deb, deb_p;
    int coin_end;
    bit m_pause, m_j2, ar, al, ad, au;
    int m_ja, m_btn;

    function automatic int nib(input bit r, input bit l, input bit d, input bit u);
        return r * 8 + l * 4 + d * 2 + u;
    endfunction

    task automatic model_reset();
        k = 0;
        for (int i = 0; i < 4; i++) run[i] = 1;
        raw_prev = 0; deb = 0; deb_p = 0;
        coin_end = -100;
        m_pause = 0; m_j2 = 0;
        ar = 0; al = 0; ad = 0; au = 0;
        m_ja = 255; m_btn = 0;
    endtask

    task automatic model_edge();
        logic [31:0] jo;
        logic [15:0] st;
        bit [3:0] raw, nd;
        int x, y, d1, d2, fire, hi, lo;
        if (!reset_n) begin
            model_reset();
            return;
        end
        jo = io.joy1 | io.joy2;
        raw = {jo[15], jo[12], jo[11], jo[10]};
        for (int i = 0; i < 4; i++) begin
            run[i] = (raw[i] == raw_prev[i]) ? run[i] + 1 : 1;
            nd[i] = (run[i] > DEB) ? raw[i] : deb[i];
        end
        if (deb[2] && !deb_p[2] && coin_end < k - 1) coin_end = k + COIN - 1;
        m_pause = !io.pause_en ? 1'b0 : (deb[3] && !deb_p[3]) ? !m_pause : m_pause;
        m_btn = deb[0] * 4 + deb[1] * 2 + ((k <= coin_end) ? 1 : 0);
        d1 = nib(io.joy1[0] | ar, io.joy1[1] | al, io.joy1[2] | ad, io.joy1[3] | au);
        d2 = nib(io.joy2[0], io.joy2[1], io.joy2[2], io.joy2[3]);
        fire = nib(jo[4], jo[7], jo[5], jo[6]);
        case (io.mode)
            2'd0: begin hi = fire; lo = d1 | d2; end
            2'd1: begin hi = d1 | d2; lo = d1 | d2; end
            default: begin hi = d2; lo = d1; end
        endcase
        m_ja = 255 - (hi * 16 + lo);
        st = m_j2 ? io.joy2a : io.joy1a;
        x = int'($signed(st[7:0]));
        y = int'($signed(st[15:8]));
        ar = (x >= THR) ? 1'b1 : (x < REL) ? 1'b0 : ar;
        al = (x <= -THR) ? 1'b1 : (x > -REL) ? 1'b0 : al;
        ad = (y >= THR) ? 1'b1 : (y < REL) ? 1'b0 : ad;
        au = (y <= -THR) ? 1'b1 : (y > -REL) ? 1'b0 : au;
        m_j2 = (io.joy1 != 0) ? 1'b0 : (io.joy2 != 0) ? 1'b1 : m_j2;
        deb_p = deb;
        deb = nd;
        raw_prev = raw;
        k++;
    endtask

    task automatic step();
        @(posedge clk_sys);
        model_edge();
        #1;
        if (io.BTN[0]) coin_hi++;
        check("ja", {24'd0, io.JA}, m_ja);
        check("btn", {24'd0, io.BTN}, m_btn);
        check("pause", {31'd0, io.pause_out}, {31'd0, m_pause});
        check("j2", {31'd0, io.j2_active}, {31'd0, m_j2});
    endtask

    task automatic press(input int idx);
        io.joy1[idx] = 1'b1;
        repeat (DEB + 3) step();
        io.joy1[idx] = 1'b0;
        repeat (DEB + 3) step();
    endtask

    logic [7:0] ana_tab [12] = '{8'd0, 8'd31, 8'd32, 8'd33, 8'd47, 8'd48, 8'd49, 8'd127,
                                 8'hE1, 8'hE0, 8'hD0, 8'h80};

    initial begin
        bit [3:0] btns;
        bit p2;
        int hold;
        logic [9:0] d1, d2;
        model_reset();
        io.joy1 = '1; io.joy2 = '0; io.joy1a = '0; io.joy2a = '0;
        io.mode = 2'd0; io.pause_en = 1'b1;
        repeat (3) step();
        check("rst_btn", {24'd0, io.BTN}, 32'h00);
        check("rst_ja", {24'd0, io.JA}, 32'hFF);
        check("rst_pause", {31'd0, io.pause_out}, 32'd0);
        reset_n = 1'b1;
        step();
        check("rel_ja", {24'd0, io.JA}, 32'h00);
        io.joy1 = '0;
        repeat (20) step();

        // short coin glitch never reaches BTN
        coin_hi = 0;
        io.joy1[JOY_COIN] = 1'b1;
        repeat (5) step();
        io.joy1[JOY_COIN] = 1'b0;
        repeat (20) step();
        check("glitch", coin_hi, 0);

        io.joy1[JOY_COIN] = 1'b1;
        repeat (DEB + 1) step();
        check("coin_pre", {31'd0, io.BTN[0]}, 32'd0);
        step();
        check("coin_rise", {31'd0, io.BTN[0]}, 32'd1);
        repeat (COIN - 1) step();
        check("coin_hold", {31'd0, io.BTN[0]}, 32'd1);
        step();
        check("coin_end", {31'd0, io.BTN[0]}, 32'd0);
        coin_hi = 0;
        repeat (30) step();
        check("coin_single", coin_hi, 0);
        io.joy1[JOY_COIN] = 1'b0;
        repeat (DEB + 4) step();

        // re-press inside a pulse neither retriggers nor extends it
        coin_hi = 0;
        io.joy1[JOY_COIN] = 1'b1;
        repeat (DEB + 2) step();
        io.joy1[JOY_COIN] = 1'b0;
        repeat (DEB + 3) step();
        io.joy1[JOY_COIN] = 1'b1;
        repeat (DEB + 3) step();
        for (int n = 0; n < 2 * COIN && io.BTN[0]; n++) step();
        check("coin_noext", coin_hi, COIN);
        io.joy1[JOY_COIN] = 1'b0;
        repeat (DEB + 4) step();
        io.joy1[JOY_COIN] = 1'b1;
        repeat (DEB + 2) step();
        check("coin_second", {31'd0, io.BTN[0]}, 32'd1);
        io.joy1[JOY_COIN] = 1'b0;
        repeat (COIN + DEB + 4) step();

        press(JOY_PAUSE);
        check("pause_on", {31'd0, io.pause_out}, 32'd1);
        press(JOY_PAUSE);
        check("pause_off", {31'd0, io.pause_out}, 32'd0);
        press(JOY_PAUSE);
        io.pause_en = 1'b0;
        step();
        check("pause_clr", {31'd0, io.pause_out}, 32'd0);
        press(JOY_PAUSE);
        check("pause_blk", {31'd0, io.pause_out}, 32'd0);
        io.pause_en = 1'b1;

        // analog hysteresis on P1 stick, mode 00
        io.joy1a = 16'h0030;
        step();
        check("ana_lat", {24'd0, io.JA}, 32'hFF);
        step();
        check("ana_r48", {24'd0, io.JA}, 32'hF7);
        io.joy1a = 16'h0028;
        repeat (2) step();
        check("ana_r40", {24'd0, io.JA}, 32'hF7);
        io.joy1a = 16'h001F;
        repeat (2) step();
        check("ana_r31", {24'd0, io.JA}, 32'hFF);
        io.joy1a = 16'h0080;
        repeat (2) step();
        check("ana_l128", {24'd0, io.JA}, 32'hFB);
        io.joy1a = 16'h3000;
        repeat (2) step();
        check("ana_d48", {24'd0, io.JA}, 32'hFD);
        io.joy1a = 16'h0000;
        repeat (2) step();

        io.joy1 = 32'h1; io.joy2 = 32'h8; io.mode = 2'd2;
        step();
        check("mode_split", {24'd0, io.JA}, 32'hE7);
        check("j2_both", {31'd0, io.j2_active}, 32'd0);
        io.mode = 2'd1;
        step();
        check("mode_dual", {24'd0, io.JA}, 32'h66);
        io.mode = 2'd3;
        step();
        check("mode_split3", {24'd0, io.JA}, 32'hE7);
        io.joy1 = '0;
        step();
        check("j2_set", {31'd0, io.j2_active}, 32'd1);
        io.joy2 = '0; io.mode = 2'd0; io.joy2a = 16'h0030;
        repeat (2) step();
        check("ana_p2", {24'd0, io.JA}, 32'hF7);
        check("j2_hold", {31'd0, io.j2_active}, 32'd1);

        hold = 0; btns = 0; p2 = 0; d1 = 0; d2 = 0;
        for (int c = 0; c < 4000; c++) begin
            if (hold == 0) begin
                for (int b = 0; b < 4; b++) btns[b] = ($urandom_range(0, 2) == 0);
                p2 = $urandom_range(0, 1) == 1;
                hold = $urandom_range(1, 3 * DEB);
            end
            hold--;
            if ($urandom_range(0, 3) == 0) begin
                d1 = ($urandom_range(0, 2) == 0) ? 10'd0 : 10'($urandom);
                d2 = ($urandom_range(0, 2) == 0) ? 10'd0 : 10'($urandom);
            end
            io.joy1 = p2 ? {22'd0, d1} : {16'd0, btns[3], 2'b00, btns[2:0], d1};
            io.joy2 = p2 ? {16'd0, btns[3], 2'b00, btns[2:0], d2} : {22'd0, d2};
            if ($urandom_range(0, 7) == 0) begin
                io.joy1a = {ana_tab[$urandom_range(0, 11)], ana_tab[$urandom_range(0, 11)]};
                io.joy2a = {ana_tab[$urandom_range(0, 11)], ana_tab[$urandom_range(0, 11)]};
            end
            if ($urandom_range(0, 63) == 0) io.mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) io.pause_en = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 499) == 0) begin
                #2;
                reset_n = 1'b0;
                #1;
                model_reset();
                check("arst_btn", {24'd0, io.BTN}, 32'h00);
                check("arst_ja", {24'd0, io.JA}, 32'hFF);
                check("arst_pause", {31'd0, io.pause_out}, 32'd0);
                repeat (2) step();
                reset_n = 1'b1;
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
